// File: rtl/mul_arbiter.sv
// Round-robin arbiter in front of a shared two-stage signed fixed-point multiplier.
// Responses return in acceptance order with a one-hot owner tag.
module mul_arbiter #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned BIN_POS    = 8,
    parameter int unsigned NUM_REQ    = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_lhs,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_rhs,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            resp_valid,
    output logic [DATA_WIDTH-1:0]         resp_data,
    output logic                          busy,
    output logic [15:0]                   op_count
);

    localparam int unsigned PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0]             ptr_q;
    logic [PTR_W-1:0]             grant_idx;
    logic [PTR_W-1:0]             cand;
    logic                         grant_found;
    logic                         accept;
    logic [31:0]                  ptr_int;

    logic                         s1_valid_q;
    logic [PTR_W-1:0]             s1_owner_q;
    logic signed [DATA_WIDTH-1:0] s1_lhs_q;
    logic signed [DATA_WIDTH-1:0] s1_rhs_q;

    logic                         s2_valid_q;
    logic [PTR_W-1:0]             s2_owner_q;
    logic [DATA_WIDTH-1:0]        resp_data_q;
    logic [15:0]                  op_count_q;

    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [2*DATA_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0]          prod_lo;
    logic                           unused_shift_hi;

    assign ptr_int = {{(32-PTR_W){1'b0}}, ptr_q};

    // Search starts one past the last winner and wraps, so the last winner goes last.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = PTR_W'((ptr_int + k) % NUM_REQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (rst && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign accept = |req_ready;

    // Full-width signed product, arithmetic shift floors toward -inf, low bits wrap.
    assign prod            = s1_lhs_q * s1_rhs_q;
    assign shifted         = prod >>> BIN_POS;
    assign prod_lo         = shifted[DATA_WIDTH-1:0];
    assign unused_shift_hi = ^shifted[2*DATA_WIDTH-1:DATA_WIDTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q       <= PTR_W'(NUM_REQ - 1);
            s1_valid_q  <= 1'b0;
            s1_owner_q  <= '0;
            s1_lhs_q    <= '0;
            s1_rhs_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_owner_q  <= '0;
            resp_data_q <= '0;
            op_count_q  <= '0;
        end else begin
            s1_valid_q <= accept;
            if (accept) begin
                ptr_q      <= grant_idx;
                s1_owner_q <= grant_idx;
                s1_lhs_q   <= req_lhs[grant_idx*DATA_WIDTH +: DATA_WIDTH];
                s1_rhs_q   <= req_rhs[grant_idx*DATA_WIDTH +: DATA_WIDTH];
            end
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_owner_q  <= s1_owner_q;
                resp_data_q <= prod_lo;
                op_count_q  <= op_count_q + 16'd1;
            end
        end
    end

    always_comb begin
        resp_valid = '0;
        if (s2_valid_q) begin
            resp_valid[s2_owner_q] = 1'b1;
        end
    end

    assign resp_data = resp_data_q;
    assign busy      = s1_valid_q | s2_valid_q;
    assign op_count  = op_count_q;

    a_ready_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(req_ready));
    a_ready_valid:  assert property (@(posedge clk) disable iff (!rst)
                                     (req_ready & ~req_valid) == '0);

endmodule

// File: tb/tb_mul_arbiter.sv
// Directed bench for mul_arbiter (16-bit, 8 fractional bits, 4 requesters).
// Expected products and grant order are hand-computed constants.
module tb_mul_arbiter;

    localparam int DW = 16;
    localparam int NR = 4;

    logic             clk;
    logic             rst;
    logic [NR-1:0]    req_valid;
    logic [NR*DW-1:0] req_lhs;
    logic [NR*DW-1:0] req_rhs;
    logic [NR-1:0]    req_ready;
    logic [NR-1:0]    resp_valid;
    logic [DW-1:0]    resp_data;
    logic             busy;
    logic [15:0]      op_count;

    int checks;
    int failures;
    int exp_count;

    mul_arbiter #(
        .DATA_WIDTH(DW),
        .BIN_POS   (8),
        .NUM_REQ   (NR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_lhs   (req_lhs),
        .req_rhs   (req_rhs),
        .req_ready (req_ready),
        .resp_valid(resp_valid),
        .resp_data (resp_data),
        .busy      (busy),
        .op_count  (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int idx, input logic [DW-1:0] lhs, input logic [DW-1:0] rhs);
        req_lhs[idx*DW +: DW] = lhs;
        req_rhs[idx*DW +: DW] = rhs;
    endtask

    task automatic expect_resp(input string tag, input int owner, input logic [DW-1:0] data);
        logic [NR-1:0] oh;
        oh = '0;
        oh[owner] = 1'b1;
        exp_count++;
        check({tag, "_valid"}, 32'(resp_valid), 32'(oh));
        check({tag, "_data"}, 32'(resp_data), 32'(data));
        check({tag, "_count"}, 32'(op_count), exp_count);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        tick();
        @(negedge clk);
        rst = 1'b1;
        exp_count = 0;
        tick();
    endtask

    initial begin
        logic [NR-1:0] oh;
        checks    = 0;
        failures  = 0;
        exp_count = 0;
        rst       = 1'b0;
        req_valid = '0;
        req_lhs   = '0;
        req_rhs   = '0;

        // Reset values, and no grants while reset is held
        tick();
        req_valid = 4'hF;
        #1;
        check("rst_ready", 32'(req_ready), 0);
        check("rst_resp_valid", 32'(resp_valid), 0);
        check("rst_resp_data", 32'(resp_data), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_op_count", 32'(op_count), 0);
        req_valid = '0;
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Single request from requester 2: 1.5 * 2.0 = 3.0
        set_ops(2, 16'h0180, 16'h0200);
        req_valid = 4'b0100;
        #1;
        check("single_ready", 32'(req_ready), 32'b0100);
        tick();
        req_valid = '0;
        check("single_busy", 32'(busy), 1);
        check("single_no_early", 32'(resp_valid), 0);
        tick();
        expect_resp("single", 2, 16'h0300);
        tick();
        check("single_pulse_end", 32'(resp_valid), 0);
        check("single_hold", 32'(resp_data), 32'h0300);
        check("single_idle", 32'(busy), 0);

        // Back-to-back sign/truncation cases, then overflow wrap
        set_ops(0, 16'hFF00, 16'h0080);
        set_ops(1, 16'hFFFF, 16'h0001);
        set_ops(3, 16'h7F00, 16'h0200);
        req_valid = 4'b0001;
        #1;
        check("neg_ready", 32'(req_ready), 32'b0001);
        tick();
        req_valid = 4'b0010;
        tick();
        req_valid = 4'b1000;
        expect_resp("neg", 0, 16'hFF80);
        tick();
        req_valid = '0;
        expect_resp("floor", 1, 16'hFFFF);
        tick();
        expect_resp("wrap", 3, 16'hFE00);
        tick();

        // Round-robin with all requesters held valid after a fresh reset
        do_reset();
        check("rr_count_reset", 32'(op_count), 0);
        for (int i = 0; i < NR; i++) set_ops(i, 16'((i + 1) * 256), 16'h0200);
        req_valid = 4'hF;
        for (int c = 0; c < 8; c++) begin
            #1;
            oh = '0;
            oh[c % NR] = 1'b1;
            check($sformatf("rr_grant%0d", c), 32'(req_ready), 32'(oh));
            tick();
            if (c >= 1) expect_resp($sformatf("rr_resp%0d", c - 1), (c - 1) % NR,
                                    16'(((c - 1) % NR + 1) * 512));
        end
        req_valid = '0;
        tick();
        expect_resp("rr_resp7", 3, 16'h0800);
        tick();

        // Sparse requests: after a grant to 1, 0b1010 goes to 3 then 1
        req_valid = 4'b0010;
        #1;
        check("sparse_g1", 32'(req_ready), 32'b0010);
        tick();
        req_valid = 4'b1010;
        #1;
        check("sparse_g3", 32'(req_ready), 32'b1000);
        tick();
        check("sparse_g1b", 32'(req_ready), 32'b0010);
        expect_resp("sparse_r1", 1, 16'h0400);
        tick();
        req_valid = '0;
        expect_resp("sparse_r3", 3, 16'h0800);
        tick();
        expect_resp("sparse_r1b", 1, 16'h0400);

        // Requester 1 loses to 2, then withdraws: it must get nothing
        req_valid = 4'b0110;
        #1;
        check("drop_ready", 32'(req_ready), 32'b0100);
        tick();
        req_valid = '0;
        check("drop_no_resp0", 32'(resp_valid), 0);
        tick();
        expect_resp("drop_r2", 2, 16'h0600);
        tick();
        check("drop_no_resp1", 32'(resp_valid), 0);
        check("drop_idle", 32'(busy), 0);

        // Reset one cycle after an accept discards the operation
        set_ops(2, 16'h0180, 16'h0200);
        req_valid = 4'b0100;
        tick();
        req_valid = '0;
        rst = 1'b0;
        #1;
        check("mid_busy", 32'(busy), 0);
        check("mid_count", 32'(op_count), 0);
        tick();
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("mid_no_resp%0d", c), 32'(resp_valid), 0);
        end
        check("mid_busy_after", 32'(busy), 0);
        check("mid_count_after", 32'(op_count), 0);
        req_valid = 4'hF;
        #1;
        check("mid_first_grant", 32'(req_ready), 32'b0001);
        req_valid = '0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
